axi_lite_initiator: RTL and testbench
=====================================

AXI_LITE_INITIATOR -- requirements
Module: axi_lite_initiator

Interface
REQ-001 The block SHALL have parameter C_M_AXI_ADDR_WIDTH, default 8, giving the AXI address width.
REQ-002 The block SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, giving the AXI data and command data width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum wait cycles per handshake phase (range 1..65535).
REQ-004 M_AXI_ACLK  in  1  single clock; every flop is rising-edge.
REQ-005 M_AXI_ARESET  in  1  reset, synchronous, active-high.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  block idle and accepting a command.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  C_M_AXI_ADDR_WIDTH  target byte address.
REQ-010 cmd_wdata  in  C_M_AXI_DATA_WIDTH  write data; ignored for reads.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_write  out  1  the completed command was a write.
REQ-013 rsp_timeout  out  1  the completed command timed out.
REQ-014 rsp_rdata  out  C_M_AXI_DATA_WIDTH  captured read data.
REQ-015 M_AXI_AWADDR out ADDR_W; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1 -- write address channel.
REQ-016 M_AXI_WDATA out DATA_W; M_AXI_WVALID out 1; M_AXI_WREADY in 1 -- write data channel.
REQ-017 M_AXI_ARADDR out ADDR_W; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1 -- read address channel.
REQ-018 M_AXI_RDATA in DATA_W; M_AXI_RVALID in 1; M_AXI_RREADY out 1 -- read data channel; there is no B channel.

Function
REQ-019 The FSM SHALL have the states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA and RESP.
REQ-020 cmd_ready SHALL equal (state == IDLE); a command SHALL be accepted on the edge where cmd_valid && cmd_ready is true.
REQ-021 On acceptance, addr/wdata/write SHALL be registered, and the FSM SHALL go to WR_ADDR (write) or RD_ADDR (read).
REQ-022 WR_ADDR: AWVALID=1 and AWADDR=latched addr, held stable until the AWVALID&&AWREADY edge; then go to WR_DATA.
REQ-023 WR_DATA: WVALID=1 and WDATA=latched data, held stable until the WVALID&&WREADY edge; then go to RESP. AWVALID and WVALID SHALL never be high together.
REQ-024 RD_ADDR: ARVALID=1, ARADDR held stable until the ARVALID&&ARREADY edge; then go to RD_DATA.
REQ-025 RD_DATA: RREADY=1; on the RVALID&&RREADY edge, capture RDATA into rsp_rdata and go to RESP.
REQ-026 All AXI valid/ready outputs SHALL be registered and driven only from the current state (no combinational path from AXI inputs).
REQ-027 RESP SHALL last exactly 1 cycle with rsp_valid=1, then go to IDLE.
REQ-028 Minimum latency, acceptance edge to rsp_valid: 3 cycles for a write (ready already high), 3 cycles for a read (ready and RVALID already high).
REQ-029 A 16-bit wait counter SHALL clear on entry to each of WR_ADDR, WR_DATA, RD_ADDR and RD_DATA, and SHALL increment on every cycle without the phase handshake.
REQ-030 If the counter equals TIMEOUT_CYCLES-1 with no handshake, the block SHALL drop the phase valid/ready next cycle, go to RESP with rsp_timeout=1, and set rsp_rdata=0.
REQ-031 A handshake on the limit cycle SHALL take priority over the timeout.
REQ-032 A write timeout in WR_ADDR SHALL skip the W phase.
REQ-033 rsp_write, rsp_timeout and rsp_rdata SHALL hold their values until the next RESP; rsp_rdata SHALL be unchanged by writes.
REQ-034 cmd_valid while busy SHALL be ignored (cmd_ready=0); there is no queuing.

Reset
REQ-035 While M_AXI_ARESET=1 at an edge: state=IDLE; all AXI valid/ready outputs, rsp_valid and rsp_timeout =0; addresses, data, rsp_rdata and rsp_write =0; counter=0.
REQ-036 Reset mid-transaction SHALL abort immediately without a response; cmd_ready=1 in the first cycle after reset is released.

Verification
REQ-037 Write 0x10 <- 0xDEADBEEF to a responder whose AWREADY arrives 2 cycles late and WREADY 3 cycles late -> AW phase then W phase with stable payload, never overlapping, followed by one rsp_valid with rsp_write=1 and rsp_timeout=0.
REQ-038 Read 0x84 with RVALID and RDATA=0x00000005 after 4 cycles -> rsp_rdata=0x00000005, rsp_write=0, exactly one rsp_valid pulse.
REQ-039 TIMEOUT_CYCLES=8, AWREADY tied 0 -> AWVALID high for exactly 8 cycles, no WVALID, then rsp_valid with rsp_timeout=1 and rsp_rdata=0.
REQ-040 TIMEOUT_CYCLES=8, ARREADY first high on the 8th wait cycle -> handshake accepted, no timeout, and the read completes normally.
REQ-041 cmd_valid held high for 3 back-to-back reads -> each is accepted only in IDLE, with one rsp_valid per command, in order.
REQ-042 Assert reset in RD_DATA -> next cycle all outputs are 0, no rsp_valid, and cmd_ready=1 after release.

Source files
------------

// File: rtl/axi_lite_initiator.sv
// Single-outstanding AXI4-Lite initiator: turns one command into an AW/W or AR/R
// sequence with a per-phase wait limit, then reports completion with a one-cycle pulse.
module axi_lite_initiator #(
    parameter int C_M_AXI_ADDR_WIDTH = 8,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 255
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESET,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_wdata,
    output logic                          rsp_valid,
    output logic                          rsp_write,
    output logic                          rsp_timeout,
    output logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RESP    = 3'd5
    } state_t;

    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    state_t                          state_r;
    state_t                          state_nx_s;
    logic                            accept_s;
    logic                            in_phase_s;
    logic                            handshake_s;
    logic                            at_limit_s;
    logic                            timeout_s;
    logic [15:0]                     wait_cnt_r;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_r;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_r;
    logic                            write_r;
    logic                            cmd_ready_r;
    logic                            awvalid_r;
    logic                            wvalid_r;
    logic                            arvalid_r;
    logic                            rready_r;
    logic                            rsp_valid_r;
    logic                            rsp_write_r;
    logic                            rsp_timeout_r;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_r;

    assign accept_s   = (state_r == IDLE) && cmd_valid;
    assign at_limit_s = (wait_cnt_r == WAIT_LIMIT);

    // Next-state selection; a handshake on the limit cycle wins over the timeout.
    always_comb begin
        state_nx_s  = state_r;
        in_phase_s  = 1'b0;
        handshake_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    state_nx_s = cmd_write ? WR_ADDR : RD_ADDR;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            WR_ADDR: begin
                in_phase_s  = 1'b1;
                handshake_s = awvalid_r && M_AXI_AWREADY;
                if (handshake_s) begin
                    state_nx_s = WR_DATA;
                end else if (at_limit_s) begin
                    state_nx_s = RESP;
                end else begin
                    state_nx_s = WR_ADDR;
                end
            end
            WR_DATA: begin
                in_phase_s  = 1'b1;
                handshake_s = wvalid_r && M_AXI_WREADY;
                if (handshake_s || at_limit_s) begin
                    state_nx_s = RESP;
                end else begin
                    state_nx_s = WR_DATA;
                end
            end
            RD_ADDR: begin
                in_phase_s  = 1'b1;
                handshake_s = arvalid_r && M_AXI_ARREADY;
                if (handshake_s) begin
                    state_nx_s = RD_DATA;
                end else if (at_limit_s) begin
                    state_nx_s = RESP;
                end else begin
                    state_nx_s = RD_ADDR;
                end
            end
            RD_DATA: begin
                in_phase_s  = 1'b1;
                handshake_s = rready_r && M_AXI_RVALID;
                if (handshake_s || at_limit_s) begin
                    state_nx_s = RESP;
                end else begin
                    state_nx_s = RD_DATA;
                end
            end
            RESP: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
        timeout_s = in_phase_s && !handshake_s && at_limit_s;
    end

    // State register.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Handshake outputs are registered copies of the state being entered, so they
    // never depend combinationally on the responder.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            cmd_ready_r <= 1'b1;
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            arvalid_r   <= 1'b0;
            rready_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            wait_cnt_r  <= 16'd0;
        end else begin
            cmd_ready_r <= (state_nx_s == IDLE);
            awvalid_r   <= (state_nx_s == WR_ADDR);
            wvalid_r    <= (state_nx_s == WR_DATA);
            arvalid_r   <= (state_nx_s == RD_ADDR);
            rready_r    <= (state_nx_s == RD_DATA);
            rsp_valid_r <= (state_nx_s == RESP);
            if (state_nx_s != state_r) begin
                wait_cnt_r <= 16'd0;
            end else if (in_phase_s) begin
                wait_cnt_r <= wait_cnt_r + 16'd1;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end
    end

    // Command payload capture and response bookkeeping; rsp_* hold between responses.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            addr_r        <= {C_M_AXI_ADDR_WIDTH{1'b0}};
            wdata_r       <= {C_M_AXI_DATA_WIDTH{1'b0}};
            write_r       <= 1'b0;
            rsp_write_r   <= 1'b0;
            rsp_timeout_r <= 1'b0;
            rsp_rdata_r   <= {C_M_AXI_DATA_WIDTH{1'b0}};
        end else begin
            if (accept_s) begin
                addr_r  <= cmd_addr;
                wdata_r <= cmd_wdata;
                write_r <= cmd_write;
            end
            if ((state_nx_s == RESP) && (state_r != RESP)) begin
                rsp_write_r   <= write_r;
                rsp_timeout_r <= timeout_s;
                if (timeout_s) begin
                    rsp_rdata_r <= {C_M_AXI_DATA_WIDTH{1'b0}};
                end else if (state_r == RD_DATA) begin
                    rsp_rdata_r <= M_AXI_RDATA;
                end
            end
        end
    end

    assign cmd_ready     = cmd_ready_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_write     = rsp_write_r;
    assign rsp_timeout   = rsp_timeout_r;
    assign rsp_rdata     = rsp_rdata_r;
    assign M_AXI_AWADDR  = addr_r;
    assign M_AXI_AWVALID = awvalid_r;
    assign M_AXI_WDATA   = wdata_r;
    assign M_AXI_WVALID  = wvalid_r;
    assign M_AXI_ARADDR  = addr_r;
    assign M_AXI_ARVALID = arvalid_r;
    assign M_AXI_RREADY  = rready_r;

endmodule

// File: tb/tb_axi_lite_initiator.sv
// Scoreboard bench for axi_lite_initiator: a delay-programmable responder, a
// negedge monitor that pops expected responses, and directed command vectors.
module tb_axi_lite_initiator;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam int NEVER = 1000;

    logic          clk = 1'b0;
    logic          M_AXI_ARESET;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_write, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
    logic          M_AXI_AWVALID, M_AXI_AWREADY;
    logic [DW-1:0] M_AXI_WDATA;
    logic          M_AXI_WVALID, M_AXI_WREADY;
    logic          M_AXI_ARVALID, M_AXI_ARREADY;
    logic [DW-1:0] M_AXI_RDATA;
    logic          M_AXI_RVALID, M_AXI_RREADY;

    always #5 clk = ~clk;

    axi_lite_initiator #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(M_AXI_ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_timeout(rsp_timeout),
        .rsp_rdata(rsp_rdata),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    typedef struct {
        logic          wr;
        logic          to;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          sb_q[$];
    int            n_checks = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            acc_cyc = 0;
    int            rsp_cyc = 0;
    int            rsp_n = 0;
    int            aw_n = 0, w_n = 0, ar_n = 0, r_n = 0;
    int            aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
    int            aw_c = 0, w_c = 0, ar_c = 0, r_c = 0;
    logic [AW-1:0] exp_addr = 8'h00;
    logic [DW-1:0] exp_wdata = 32'h0;
    logic [AW-1:0] ar_lat = 8'h00;
    logic [DW-1:0] last_rdata = 32'h0;
    logic [DW-1:0] mem [256];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Responder: ready/valid rises once the initiator has waited the programmed cycles.
    initial begin
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID = 1'b0; M_AXI_RDATA = 32'hBAD0BAD0;
        forever begin
            @(posedge clk); #1;
            if (M_AXI_AWVALID) begin M_AXI_AWREADY = (aw_c >= aw_dly); aw_c++; end
            else begin M_AXI_AWREADY = 1'b0; aw_c = 0; end
            if (M_AXI_WVALID) begin M_AXI_WREADY = (w_c >= w_dly); w_c++; end
            else begin M_AXI_WREADY = 1'b0; w_c = 0; end
            if (M_AXI_ARVALID) begin M_AXI_ARREADY = (ar_c >= ar_dly); ar_c++; ar_lat = M_AXI_ARADDR; end
            else begin M_AXI_ARREADY = 1'b0; ar_c = 0; end
            if (M_AXI_RREADY && (r_c >= r_dly)) begin
                M_AXI_RVALID = 1'b1; M_AXI_RDATA = mem[ar_lat]; r_c++;
            end else if (M_AXI_RREADY) begin
                M_AXI_RVALID = 1'b0; M_AXI_RDATA = 32'hBAD0BAD0; r_c++;
            end else begin
                M_AXI_RVALID = 1'b0; M_AXI_RDATA = 32'hBAD0BAD0; r_c = 0;
            end
        end
    end

    // Monitor: payload stability, channel exclusivity, and scoreboard pops on rsp_valid.
    initial forever begin
        @(negedge clk);
        if (!M_AXI_ARESET) begin
            if (M_AXI_AWVALID) begin aw_n++; check("awaddr", M_AXI_AWADDR, exp_addr); end
            if (M_AXI_WVALID) begin
                w_n++;
                check("wdata", M_AXI_WDATA, exp_wdata);
                check("aw_w_overlap", M_AXI_AWVALID, 1'b0);
            end
            if (M_AXI_ARVALID) begin ar_n++; check("araddr", M_AXI_ARADDR, exp_addr); end
            if (M_AXI_RREADY) r_n++;
            if (rsp_valid) begin
                rsp_n++;
                rsp_cyc = cyc;
                if (sb_q.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("rsp_write", rsp_write, e.wr);
                    check("rsp_timeout", rsp_timeout, e.to);
                    check("rsp_rdata", rsp_rdata, e.rdata);
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic to, input logic [DW-1:0] rd, input bit keep, input bit push);
        bit   accepted = 1'b0;
        logic rdy;
        exp_t e;
        check("rsp_rdata_hold", rsp_rdata, last_rdata);
        exp_addr = a; exp_wdata = d;
        aw_n = 0; w_n = 0; ar_n = 0; r_n = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        for (int i = 0; i < 50; i++) begin
            rdy = cmd_ready;
            @(posedge clk); #1;
            if (rdy) begin accepted = 1'b1; break; end
        end
        if (!accepted) begin
            n_checks++; n_err++;
            $display("FAIL accept: got no acceptance in 50 cycles expected cmd_ready");
        end
        acc_cyc = cyc;
        if (push) begin
            e.wr = wr; e.to = to; e.rdata = rd;
            sb_q.push_back(e);
            last_rdata = rd;
        end
        if (!keep) cmd_valid = 1'b0;
        check("busy_cmd_ready", cmd_ready, 1'b0);
    endtask

    task automatic wait_rsp(input int start_n);
        bit got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (rsp_n > start_n) begin got = 1'b1; break; end
        end
        if (!got) begin
            n_checks++; n_err++;
            $display("FAIL rsp_wait: got no rsp_valid in 100 cycles expected one");
        end
        check("single_pulse", rsp_valid, 1'b0);
    endtask

    task automatic txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic to, input logic [DW-1:0] rd, input int lat,
                       input int e_aw, input int e_w, input int e_ar, input int e_r, input bit keep);
        int s;
        s = rsp_n;
        issue(wr, a, d, to, rd, keep, 1'b1);
        wait_rsp(s);
        check("latency", rsp_cyc - acc_cyc + 1, lat);
        check("aw_cycles", aw_n, e_aw);
        check("w_cycles", w_n, e_w);
        check("ar_cycles", ar_n, e_ar);
        check("r_cycles", r_n, e_r);
    endtask

    task automatic reset_values();
        check("rst_awvalid", M_AXI_AWVALID, 1'b0);
        check("rst_wvalid", M_AXI_WVALID, 1'b0);
        check("rst_arvalid", M_AXI_ARVALID, 1'b0);
        check("rst_rready", M_AXI_RREADY, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_timeout", rsp_timeout, 1'b0);
        check("rst_rsp_write", rsp_write, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_awaddr", M_AXI_AWADDR, 8'h00);
        check("rst_wdata", M_AXI_WDATA, 32'h0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h84] = 32'h00000005;
        mem[8'h40] = 32'hCAFEF00D;
        mem[8'h90] = 32'h12345678;
        mem[8'h20] = 32'h11111111;
        mem[8'h24] = 32'h22222222;
        mem[8'h28] = 32'h33333333;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 32'h0;
        M_AXI_ARESET = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_values();
        M_AXI_ARESET = 1'b0;
        @(posedge clk); #1;
        check("post_rst_cmd_ready", cmd_ready, 1'b1);

        // Late AWREADY (2) and WREADY (3); rsp_rdata keeps its reset value.
        aw_dly = 2; w_dly = 3; ar_dly = 0; r_dly = 0;
        txn(1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 32'h0, 8, 3, 4, 0, 0, 1'b0);
        // Read with RVALID after 4 wait cycles.
        aw_dly = 0; w_dly = 0; r_dly = 4;
        txn(1'b0, 8'h84, 32'h0, 1'b0, 32'h00000005, 7, 0, 0, 1, 5, 1'b0);
        // Minimum latency write; rsp_rdata untouched by the write.
        r_dly = 0;
        txn(1'b1, 8'h44, 32'h0BADF00D, 1'b0, 32'h00000005, 3, 1, 1, 0, 0, 1'b0);
        // Minimum latency read.
        txn(1'b0, 8'h40, 32'h0, 1'b0, 32'hCAFEF00D, 3, 0, 0, 1, 1, 1'b0);
        // AWREADY never: 8 AW cycles, no W phase, timeout clears rsp_rdata.
        aw_dly = NEVER;
        txn(1'b1, 8'h18, 32'h55AA55AA, 1'b1, 32'h0, 9, 8, 0, 0, 0, 1'b0);
        // ARREADY on the 8th wait cycle wins over the timeout.
        aw_dly = 0; ar_dly = 7;
        txn(1'b0, 8'h90, 32'h0, 1'b0, 32'h12345678, 10, 0, 0, 8, 1, 1'b0);
        // RVALID never: timeout in the R phase.
        ar_dly = 0; r_dly = NEVER;
        txn(1'b0, 8'h84, 32'h0, 1'b1, 32'h0, 10, 0, 0, 1, 8, 1'b0);
        // Three reads with cmd_valid held high throughout.
        r_dly = 0;
        txn(1'b0, 8'h20, 32'h0, 1'b0, 32'h11111111, 3, 0, 0, 1, 1, 1'b1);
        txn(1'b0, 8'h24, 32'h0, 1'b0, 32'h22222222, 3, 0, 0, 1, 1, 1'b1);
        txn(1'b0, 8'h28, 32'h0, 1'b0, 32'h33333333, 3, 0, 0, 1, 1, 1'b0);

        // Reset while waiting in RD_DATA: abort without a response.
        r_dly = NEVER;
        issue(1'b0, 8'h84, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (M_AXI_RREADY) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        check("reached_rd_data", seen, 1'b1);
        M_AXI_ARESET = 1'b1;
        @(posedge clk); #1;
        last_rdata = 32'h0;
        reset_values();
        M_AXI_ARESET = 1'b0;
        r_dly = 0;
        @(posedge clk); #1;
        check("abort_cmd_ready", cmd_ready, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_rsp", rsp_n, 10);

        // Normal operation after the abort.
        txn(1'b1, 8'h30, 32'hA5A5A5A5, 1'b0, 32'h0, 3, 1, 1, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
